tr_issue_seq: RTL and testbench



---
 rtl/tr_pkg.sv | 36 +++
 rtl/tr_issue_seq.sv | 167 ++++++++++++++++
 tb/tb_tr_issue_seq.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/tr_pkg.sv
// Shared constants, state encoding and instruction packing for the
// R-type datapath issue sequencer.
package tr_pkg;

    localparam logic [5:0]  OPC_STORE = 6'b000000;
    localparam logic [5:0]  OPC_READ  = 6'b000001;

    localparam logic [5:0]  FUNCT_ADD = 6'b100000;
    localparam logic [5:0]  FUNCT_SUB = 6'b100010;
    localparam logic [5:0]  FUNCT_SLT = 6'b101010;

    // A read of r0: keeps the datapath quiet between commands.
    localparam logic [31:0] IDLE_WORD = 32'h0400_0000;

    typedef enum logic [1:0] {
        IDLE,
        STORE,
        READ,
        RESP
    } state_e;

    function automatic logic [31:0] pack_rtype(
        input logic [5:0] opc,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic [4:0] rd,
        input logic [5:0] funct
    );
        return {opc, rs, rt, rd, 5'b00000, funct};
    endfunction

    function automatic logic funct_legal(input logic [5:0] funct);
        return (funct == FUNCT_ADD) || (funct == FUNCT_SUB) || (funct == FUNCT_SLT);
    endfunction

endpackage

// File: rtl/tr_issue_seq.sv
// Issues a STORE then a READ R-type word per accepted command and hands the
// sampled datapath result back over a valid/ready handshake.
module tr_issue_seq
    import tr_pkg::*;
#(
    parameter int WRITE_CYCLES = 1,
    parameter int READ_LAT     = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [4:0]       cmd_rs,
    input  logic [4:0]       cmd_rt,
    input  logic [4:0]       cmd_rd,
    input  logic [5:0]       cmd_funct,
    output logic [31:0]      instruccion_TR,
    input  logic [31:0]      tr_salida_final,
    input  logic             tr_zf,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic             res_zf,
    output logic             res_err,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    localparam int MAX_CYC = (WRITE_CYCLES > READ_LAT) ? WRITE_CYCLES : READ_LAT;
    localparam int PH_W    = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [PH_W-1:0] WR_LOAD = PH_W'(WRITE_CYCLES - 1);
    localparam logic [PH_W-1:0] RD_LOAD = PH_W'(READ_LAT - 1);

    state_e            state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [4:0]        rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [5:0]        funct_q, funct_d;
    logic [31:0]       instr_q, instr_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              res_valid_q, res_valid_d;
    logic [31:0]       res_data_q, res_data_d;
    logic              res_zf_q, res_zf_d;
    logic              res_err_q, res_err_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  op_count_q, op_count_d;

    // Next-state logic; every output is computed one cycle ahead so it leaves a flop.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        rs_d        = rs_q;
        rt_d        = rt_q;
        rd_d        = rd_q;
        funct_d     = funct_q;
        instr_d     = instr_q;
        cmd_ready_d = cmd_ready_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_zf_d    = res_zf_q;
        res_err_d   = res_err_q;
        busy_d      = busy_q;
        op_count_d  = op_count_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    rs_d        = cmd_rs;
                    rt_d        = cmd_rt;
                    rd_d        = cmd_rd;
                    funct_d     = cmd_funct;
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    if (funct_legal(cmd_funct)) begin
                        state_d = STORE;
                        phase_d = WR_LOAD;
                        instr_d = pack_rtype(OPC_STORE, cmd_rs, cmd_rt, cmd_rd, cmd_funct);
                    end else begin
                        state_d     = RESP;
                        res_valid_d = 1'b1;
                        res_err_d   = 1'b1;
                        res_data_d  = 32'd0;
                        res_zf_d    = 1'b0;
                    end
                end
            end
            STORE: begin
                if (phase_q == '0) begin
                    state_d = READ;
                    phase_d = RD_LOAD;
                    instr_d = pack_rtype(OPC_READ, rs_q, rt_q, rd_q, funct_q);
                end else begin
                    phase_d = phase_q - PH_W'(1);
                end
            end
            READ: begin
                if (phase_q == '0) begin
                    state_d     = RESP;
                    instr_d     = IDLE_WORD;
                    res_valid_d = 1'b1;
                    res_data_d  = tr_salida_final;
                    res_zf_d    = tr_zf;
                    res_err_d   = 1'b0;
                end else begin
                    phase_d = phase_q - PH_W'(1);
                end
            end
            RESP: begin
                if (res_ready) begin
                    state_d     = IDLE;
                    res_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    busy_d      = 1'b0;
                    op_count_d  = op_count_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset wins over any handshake on the same edge and drops an in-flight result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            funct_q     <= '0;
            instr_q     <= IDLE_WORD;
            cmd_ready_q <= 1'b1;
            res_valid_q <= 1'b0;
            res_data_q  <= 32'd0;
            res_zf_q    <= 1'b0;
            res_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            rd_q        <= rd_d;
            funct_q     <= funct_d;
            instr_q     <= instr_d;
            cmd_ready_q <= cmd_ready_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_zf_q    <= res_zf_d;
            res_err_q   <= res_err_d;
            busy_q      <= busy_d;
            op_count_q  <= op_count_d;
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign instruccion_TR = instr_q;
    assign res_valid      = res_valid_q;
    assign res_data       = res_data_q;
    assign res_zf         = res_zf_q;
    assign res_err        = res_err_q;
    assign busy           = busy_q;
    assign op_count       = op_count_q;

endmodule

// File: tb/tb_tr_issue_seq.sv
// Drives two sequencers (default timing and WRITE_CYCLES=2/READ_LAT=3) with
// directed and random commands and checks them against a per-command model.
module tb_tr_issue_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst, cmdValid, resReady, trZf;
    logic [1:0][4:0]  cmdRs, cmdRt, cmdRd;
    logic [1:0][5:0]  cmdFunct;
    logic [1:0][31:0] trSalida;
    wire  [1:0]       cmdReady, resValid, resZf, resErr, busy;
    wire  [1:0][31:0] instr, resData;
    wire  [1:0][15:0] opCount;

    int checks = 0;
    int errors = 0;
    int opModel [2];

    tr_issue_seq #(.WRITE_CYCLES(1), .READ_LAT(1), .CNT_W(16)) dutA (
        .clk(clk), .rst(rst[0]), .cmd_valid(cmdValid[0]), .cmd_ready(cmdReady[0]),
        .cmd_rs(cmdRs[0]), .cmd_rt(cmdRt[0]), .cmd_rd(cmdRd[0]), .cmd_funct(cmdFunct[0]),
        .instruccion_TR(instr[0]), .tr_salida_final(trSalida[0]), .tr_zf(trZf[0]),
        .res_valid(resValid[0]), .res_ready(resReady[0]), .res_data(resData[0]),
        .res_zf(resZf[0]), .res_err(resErr[0]), .busy(busy[0]), .op_count(opCount[0])
    );

    tr_issue_seq #(.WRITE_CYCLES(2), .READ_LAT(3), .CNT_W(16)) dutB (
        .clk(clk), .rst(rst[1]), .cmd_valid(cmdValid[1]), .cmd_ready(cmdReady[1]),
        .cmd_rs(cmdRs[1]), .cmd_rt(cmdRt[1]), .cmd_rd(cmdRd[1]), .cmd_funct(cmdFunct[1]),
        .instruccion_TR(instr[1]), .tr_salida_final(trSalida[1]), .tr_zf(trZf[1]),
        .res_valid(resValid[1]), .res_ready(resReady[1]), .res_data(resData[1]),
        .res_zf(resZf[1]), .res_err(resErr[1]), .busy(busy[1]), .op_count(opCount[1])
    );

    // Phase lengths of each instance, as configured above.
    function automatic int writeCycles(input int s);
        return (s == 0) ? 1 : 2;
    endfunction

    function automatic int readLat(input int s);
        return (s == 0) ? 1 : 3;
    endfunction

    // Instruction word assembled arithmetically from its fields.
    function automatic logic [31:0] expWord(input int opc, input logic [4:0] rs,
                                            input logic [4:0] rt, input logic [4:0] rd,
                                            input logic [5:0] fn);
        return (32'(opc) << 26) + (32'(rs) << 21) + (32'(rt) << 16) + (32'(rd) << 11) + 32'(fn);
    endfunction

    function automatic bit isLegal(input logic [5:0] fn);
        return (fn == 6'd32) || (fn == 6'd34) || (fn == 6'd42);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Presents one command for a single edge, then scrambles the inputs so
    // any late sampling of cmd_* shows up in the issued words.
    task automatic applyStimulus(input int s, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic [5:0] fn);
        cmdValid[s] = 1'b1;
        cmdRs[s]    = rs;
        cmdRt[s]    = rt;
        cmdRd[s]    = rd;
        cmdFunct[s] = fn;
        @(negedge clk);
        cmdValid[s] = 1'b0;
        cmdRs[s]    = 5'($urandom);
        cmdRt[s]    = 5'($urandom);
        cmdRd[s]    = 5'($urandom);
        cmdFunct[s] = 6'($urandom);
    endtask

    task automatic checkIdle(input int s, input string tag);
        checkOutput($sformatf("d%0d_%s_word", s, tag), instr[s], 32'h0400_0000);
        checkOutput($sformatf("d%0d_%s_ready", s, tag), 32'(cmdReady[s]), 32'd1);
        checkOutput($sformatf("d%0d_%s_valid", s, tag), 32'(resValid[s]), 32'd0);
        checkOutput($sformatf("d%0d_%s_busy", s, tag), 32'(busy[s]), 32'd0);
        checkOutput($sformatf("d%0d_%s_count", s, tag), 32'(opCount[s]), 32'(opModel[s]));
    endtask

    // Full command: expected words per cycle, datapath value only valid in the
    // final READ cycle, then a response stalled for 'stall' cycles.
    task automatic runCmd(input int s, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [5:0] fn,
                          input logic [31:0] result, input int stall);
        logic [31:0] expData;
        logic        expZf;
        logic        expErr;
        checkOutput($sformatf("d%0d_accept_ready", s), 32'(cmdReady[s]), 32'd1);
        applyStimulus(s, rs, rt, rd, fn);
        if (isLegal(fn)) begin
            for (int i = 0; i < writeCycles(s); i++) begin
                checkOutput($sformatf("d%0d_store_word", s), instr[s], expWord(0, rs, rt, rd, fn));
                checkOutput($sformatf("d%0d_store_ready", s), 32'(cmdReady[s]), 32'd0);
                checkOutput($sformatf("d%0d_store_busy", s), 32'(busy[s]), 32'd1);
                trSalida[s] = $urandom;
                trZf[s]     = 1'($urandom);
                @(negedge clk);
            end
            for (int i = 0; i < readLat(s); i++) begin
                checkOutput($sformatf("d%0d_read_word", s), instr[s], expWord(1, rs, rt, rd, fn));
                checkOutput($sformatf("d%0d_read_valid", s), 32'(resValid[s]), 32'd0);
                if (i == readLat(s) - 1) begin
                    trSalida[s] = result;
                    trZf[s]     = (result == 32'd0);
                end else begin
                    trSalida[s] = ~result;
                    trZf[s]     = (result != 32'd0);
                end
                @(negedge clk);
            end
            expData = result;
            expZf   = (result == 32'd0);
            expErr  = 1'b0;
        end else begin
            expData = 32'd0;
            expZf   = 1'b0;
            expErr  = 1'b1;
        end
        trSalida[s] = $urandom;
        trZf[s]     = 1'($urandom);
        for (int k = 0; k <= stall; k++) begin
            checkOutput($sformatf("d%0d_resp_valid", s), 32'(resValid[s]), 32'd1);
            checkOutput($sformatf("d%0d_resp_data", s), resData[s], expData);
            checkOutput($sformatf("d%0d_resp_zf", s), 32'(resZf[s]), 32'(expZf));
            checkOutput($sformatf("d%0d_resp_err", s), 32'(resErr[s]), 32'(expErr));
            checkOutput($sformatf("d%0d_resp_word", s), instr[s], 32'h0400_0000);
            checkOutput($sformatf("d%0d_resp_ready", s), 32'(cmdReady[s]), 32'd0);
            resReady[s] = (k == stall);
            cmdValid[s] = (k == 0) && (stall > 0);
            cmdFunct[s] = 6'd32;
            @(negedge clk);
        end
        resReady[s] = 1'b0;
        cmdValid[s] = 1'b0;
        opModel[s]  = (opModel[s] + 1) % 65536;
        checkIdle(s, "post");
    endtask

    initial begin
        logic [5:0]  fn;
        logic [31:0] res;
        int          s;
        int          pick;

        rst      = 2'b11;
        cmdValid = '0;
        resReady = '0;
        trZf     = '0;
        cmdRs    = '0;
        cmdRt    = '0;
        cmdRd    = '0;
        cmdFunct = '0;
        trSalida = '0;
        opModel[0] = 0;
        opModel[1] = 0;
        $display("[TB] starting");

        // Two reset cycles, then both sequencers must sit in their idle state.
        @(negedge clk);
        @(negedge clk);
        rst = 2'b00;
        checkIdle(0, "reset");
        checkIdle(1, "reset");
        checkOutput("d0_reset_data", resData[0], 32'd0);
        checkOutput("d0_reset_err", 32'(resErr[0]), 32'd0);

        // Reset during the second READ cycle discards the command entirely.
        applyStimulus(1, 5'd7, 5'd2, 5'd3, 6'b100010);
        checkOutput("d1_rr_store0", instr[1], 32'h00E2_1822);
        @(negedge clk);
        checkOutput("d1_rr_store1", instr[1], 32'h00E2_1822);
        @(negedge clk);
        checkOutput("d1_rr_read0", instr[1], 32'h04E2_1822);
        @(negedge clk);
        checkOutput("d1_rr_read1", instr[1], 32'h04E2_1822);
        rst[1] = 1'b1;
        @(negedge clk);
        rst[1] = 1'b0;
        checkIdle(1, "midread_rst");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("d1_rr_no_valid", 32'(resValid[1]), 32'd0);
        end

        // Directed commands.
        runCmd(0, 5'd9, 5'd17, 5'd2, 6'b100000, 32'd26, 0);
        checkOutput("d0_add_store_literal", expWord(0, 5'd9, 5'd17, 5'd2, 6'b100000), 32'h0131_1020);
        runCmd(1, 5'd7, 5'd2, 5'd3, 6'b100010, 32'd0, 0);
        runCmd(0, 5'd10, 5'd5, 5'd4, 6'b101010, 32'd1, 5);
        runCmd(0, 5'd1, 5'd2, 5'd3, 6'b000111, 32'd99, 0);
        runCmd(1, 5'd4, 5'd6, 5'd8, 6'b111111, 32'd5, 2);

        // Random commands across both instances.
        for (int n = 0; n < 30; n++) begin
            s    = int'($urandom_range(0, 1));
            pick = int'($urandom_range(0, 3));
            case (pick)
                0:       fn = 6'b100000;
                1:       fn = 6'b100010;
                2:       fn = 6'b101010;
                default: fn = 6'($urandom);
            endcase
            res = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            runCmd(s, 5'($urandom), 5'($urandom), 5'($urandom), fn, res, int'($urandom_range(0, 3)));
        end

        // Reset arriving together with the result handshake must win.
        applyStimulus(0, 5'd3, 5'd4, 5'd5, 6'b100000);
        @(negedge clk);
        trSalida[0] = 32'h1234_5678;
        @(negedge clk);
        checkOutput("d0_prio_valid_before", 32'(resValid[0]), 32'd1);
        resReady[0] = 1'b1;
        rst[0]      = 1'b1;
        @(negedge clk);
        resReady[0] = 1'b0;
        rst[0]      = 1'b0;
        opModel[0]  = 0;
        checkIdle(0, "prio_rst");
        checkOutput("d0_prio_data", resData[0], 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
